// File: rtl/counter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : counter_pkg
// Description : Shared constants and next-count function for mod_counter.
//               The function works on 32-bit operands so that any counter
//               width from 2 to 32 bits can use it through zero-extension.
// Revision    : 1.0 - initial release
// ============================================================================
package counter_pkg;

    // Default count width used by mod_counter
    localparam int DEFAULT_WIDTH = 4;

    // Values of the UP input for each counting direction
    localparam logic CNT_UP   = 1'b1;
    localparam logic CNT_DOWN = 1'b0;

    // Result of one enabled counting step
    typedef struct packed {
        logic        wrap;   // step crossed the bound and restarted
        logic [31:0] value;  // next count value
    } next_t;

    // Next count for an enabled step. 'cur' and 'max' are zero-extended counter
    // values, so the arithmetic never leaves the counter's own range: the only
    // increment happens below 'max' and the only decrement happens above zero.
    function automatic next_t next_value(
        input logic [31:0] cur,
        input logic [31:0] max,
        input logic        up,
        input logic        sat
    );
        next_t res;
        res.wrap  = 1'b0;
        res.value = cur;
        if (up == CNT_UP) begin
            if (cur >= max) begin
                if (sat) begin
                    res.value = max;
                end else begin
                    res.value = 32'd0;
                    res.wrap  = 1'b1;
                end
            end else begin
                res.value = cur + 32'd1;
            end
        end else begin
            if (cur == 32'd0) begin
                if (sat) begin
                    res.value = 32'd0;
                end else begin
                    res.value = max;
                    res.wrap  = 1'b1;
                end
            end else if (cur > max) begin
                // Out of range after MAX was lowered: snap to the bound, not a wrap
                res.value = max;
            end else begin
                res.value = cur - 32'd1;
            end
        end
        return res;
    endfunction

endpackage : counter_pkg
`default_nettype wire

// File: rtl/mod_counter.sv
`default_nettype none
// ============================================================================
// Module      : mod_counter
// Description : Up/down modulo counter with run-time limit MAX (range 0..MAX),
//               synchronous clear and parallel load, combinational terminal
//               count TC and a registered one-cycle WRAP pulse.
//               Optional build macro MOD_COUNTER_SAT_EN adds input SAT, which
//               makes the counter hold at its bound instead of wrapping.
// Revision    : 1.0 - initial release
// ============================================================================
module mod_counter
    import counter_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int RESET_VAL = 0
) (
    input  logic             CLK,
    input  logic             RST,
`ifdef MOD_COUNTER_SAT_EN
    input  logic             SAT,
`endif
    input  logic             EN,
    input  logic             CLR,
    input  logic             LOAD,
    input  logic [WIDTH-1:0] LOAD_VAL,
    input  logic             UP,
    input  logic [WIDTH-1:0] MAX,
    output logic [WIDTH-1:0] Dout,
    output logic             TC,
    output logic             WRAP
);

    localparam logic [WIDTH-1:0] c_reset_val = WIDTH'(RESET_VAL);

    logic [WIDTH-1:0] r_cnt;
    logic             r_wrap;
    logic             w_sat;
    next_t            w_nv;
    logic [WIDTH-1:0] w_step_val;
    logic [WIDTH-1:0] w_load_val;

`ifdef MOD_COUNTER_SAT_EN
    assign w_sat = SAT;
`else
    assign w_sat = 1'b0;
`endif

    // Next value of an enabled step and clipped load value
    always_comb begin
        w_nv       = next_value(32'(r_cnt), 32'(MAX), UP, w_sat);
        w_step_val = w_nv.value[WIDTH-1:0];
        w_load_val = (LOAD_VAL > MAX) ? MAX : LOAD_VAL;
    end

    // Upper bits of the function result are always zero for narrow counters
    generate
        if (WIDTH < 32) begin : g_pad
            logic w_unused_hi;
            assign w_unused_hi = |w_nv.value[31:WIDTH];
        end
    endgenerate

    // Count and wrap registers, priority RST > CLR > LOAD > EN
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_cnt  <= c_reset_val;
            r_wrap <= 1'b0;
        end else if (CLR) begin
            r_cnt  <= '0;
            r_wrap <= 1'b0;
        end else if (LOAD) begin
            r_cnt  <= w_load_val;
            r_wrap <= 1'b0;
        end else if (EN) begin
            r_cnt  <= w_step_val;
            r_wrap <= w_nv.wrap;
        end else begin
            r_wrap <= 1'b0;
        end
    end

    // Terminal count: enabled and sitting at the bound of the current direction
    always_comb begin
        TC = EN & (((UP == CNT_UP) & (r_cnt >= MAX)) |
                   ((UP == CNT_DOWN) & (r_cnt == '0)));
    end

    assign Dout = r_cnt;
    assign WRAP = r_wrap;

endmodule : mod_counter
`default_nettype wire

// File: doc/mod_counter.md
MOD_COUNTER -- requirements
Module: mod_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 4, giving the count width in bits (legal range 2..32).
REQ-002 SHALL have parameter RESET_VAL, default 0, giving the count loaded on reset (must be < 2^WIDTH).
REQ-003 SHALL have port CLK  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port RST  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port EN  input  1  count enable for one step per cycle.
REQ-006 SHALL have port CLR  input  1  synchronous clear to 0.
REQ-007 SHALL have port LOAD  input  1  synchronous parallel load.
REQ-008 SHALL have port LOAD_VAL  input  WIDTH  value for LOAD.
REQ-009 SHALL have port UP  input  1  direction: 1 = increment, 0 = decrement.
REQ-010 SHALL have port MAX  input  WIDTH  run-time modulus limit; the count range is 0..MAX.
REQ-011 SHALL have port Dout  output  WIDTH  registered count value.
REQ-012 SHALL have port TC  output  1  combinational terminal count: EN and at the bound for the current direction.
REQ-013 SHALL have port WRAP  output  1  registered one-cycle pulse, high in the cycle after a wrap occurs.

Function
REQ-014 SHALL apply priority per cycle as RST > CLR > LOAD > EN; an idle cycle (none asserted) holds Dout.
REQ-015 SHALL, on CLR, set Dout to 0 and WRAP to 0.
REQ-016 SHALL, on LOAD, set Dout to min(LOAD_VAL, MAX) and WRAP to 0; EN is ignored that cycle.
REQ-017 SHALL, on EN with UP=1, set Dout to Dout+1 when Dout < MAX; when Dout >= MAX it sets Dout to 0 (wrap).
REQ-018 SHALL, on EN with UP=0, set Dout to Dout-1 when 0 < Dout <= MAX; at Dout = 0 it sets Dout to MAX (wrap); when Dout > MAX it sets Dout to MAX.
REQ-019 SHALL drive TC = EN & ((UP & Dout >= MAX) | (~UP & Dout == 0)), with no register stage.
REQ-020 SHALL assert WRAP for exactly one cycle after each enabled wrap of REQ-017 or REQ-018; back-to-back wraps (MAX = 0) keep WRAP high continuously.
REQ-021 SHALL perform all arithmetic at WIDTH bits with no overflow beyond the bound; MAX = 2^WIDTH-1 behaves as a plain binary counter.
REQ-022 SHALL, when MAX changes mid-count, apply the new MAX from the next edge only; no glitch or extra WRAP is permitted.
REQ-023 SHALL have a latency of 1 cycle from any control input to Dout.

Reset
REQ-024 SHALL, on RST high at an edge, set Dout = RESET_VAL and WRAP = 0, overriding all other inputs.
REQ-025 SHALL drive TC from the reset Dout value in the cycle after reset; there are no asynchronous paths.

Configuration
REQ-026 SHALL support macro MOD_COUNTER_SAT_EN; when it is defined, the block adds input port SAT (1 bit).
REQ-027 SHALL, with MOD_COUNTER_SAT_EN defined and SAT=1, hold Dout at the bound instead of wrapping (MAX going up, 0 going down) and never assert WRAP; TC remains asserted while held.
REQ-028 SHALL, without MOD_COUNTER_SAT_EN, have no SAT port and always wrap; behaviour is then identical to the macro-defined build with SAT=0.

Structure
REQ-029 SHALL place the default-width constant, the direction constants (CNT_UP/CNT_DOWN) and the next-value function in a shared package, counter_pkg.
REQ-030 SHALL be a single flat module with no sub-module; the datapath is next-value mux, bound compare and two registers.

Verification
REQ-031 SHALL cover: WIDTH=4, MAX=9, UP=1, EN=1 from reset -> Dout counts 0..9, then 0; WRAP high in the cycle Dout shows 0; TC high when Dout = 9.
REQ-032 SHALL cover: UP=0, MAX=5, Dout=0, EN=1 -> Dout = 5 next cycle with WRAP pulse; then 4, 3, and so on.
REQ-033 SHALL cover: LOAD=1, LOAD_VAL=12, MAX=9 -> Dout = 9; with LOAD and EN in the same cycle, LOAD_VAL=3 -> Dout = 3, not 4.
REQ-034 SHALL cover: Dout=7, then MAX changed to 4 with UP=1, EN=1 -> Dout = 0 next cycle, WRAP = 1; with UP=0 -> Dout = 4.
REQ-035 SHALL cover: RST and CLR and LOAD all high, RESET_VAL=3 -> Dout = 3; CLR alone -> Dout = 0; mid-count RST -> Dout = 3 and WRAP = 0 next cycle.
REQ-036 SHALL cover: with MOD_COUNTER_SAT_EN, SAT=1, MAX=9, Dout=9, EN=1 for 3 cycles -> Dout stays 9, WRAP stays 0, TC stays 1.
